// File: rtl/vpu_pkg.sv
// Shared VPU constants and types used by the FP result buffer.
package vpu_pkg;

  localparam int OPERAND_WIDTH  = 32;
  localparam int FP_ADD_LATENCY = 12;
  localparam int RBUF_DEPTH     = 8;

  typedef enum logic {
    DRAIN = 1'b0,
    RUN   = 1'b1
  } drain_state_e;

endpackage

// File: rtl/vpu_rbuf_fifo.sv
// Result FIFO: wrap-bit pointers, storage array, full/empty and sticky overflow.
module vpu_rbuf_fifo
  import vpu_pkg::*;
#(
  parameter int DEPTH      = RBUF_DEPTH,
  parameter int DATA_WIDTH = OPERAND_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_pop  = pop & ~empty;
  // A pop frees the slot being written, so push-while-full is legal with a pop.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push & full & ~do_pop) overflow <= 1'b1;
    end
  end

  // NOTE: storage is not reset; rd_data is gated by empty so stale words never escape.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/vpu_fp_result_buffer.sv
// FP add/sub result buffer with issue-credit gating and post-reset drain window.
// Optional same-cycle bypass when the FIFO is empty: define VPU_FP_RBUF_BYPASS_EN.
module vpu_fp_result_buffer
  import vpu_pkg::*;
#(
  parameter int DEPTH      = RBUF_DEPTH,
  parameter int DATA_WIDTH = OPERAND_WIDTH,
  parameter int FP_LATENCY = FP_ADD_LATENCY
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         issue_valid_i,
  output logic                         issue_ready_o,
  output logic                         fp_start_o,
  input  logic                         fp_done_i,
  input  logic [DATA_WIDTH-1:0]        fp_result_i,
  output logic                         result_valid_o,
  output logic [DATA_WIDTH-1:0]        result_o,
  input  logic                         result_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]   credits_o,
  output logic                         overflow_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int DW = $clog2(FP_LATENCY + 2);

  drain_state_e          state_q, state_d;
  logic [DW-1:0]         drain_cnt_q, drain_cnt_d;
  logic                  draining;
  logic [CW-1:0]         credits_q;
  logic                  result_pop;
  logic                  bypass_valid;
  logic                  fifo_push;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [DATA_WIDTH-1:0] fifo_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= DRAIN;
      drain_cnt_q <= DW'(FP_LATENCY);
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // NOTE: defaults first so every path assigns state_d/drain_cnt_d and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      DRAIN: begin
        if (drain_cnt_q != '0) drain_cnt_d = drain_cnt_q - DW'(1);
        // Leave on the edge that brings the count to zero, so issue opens FP_LATENCY cycles out.
        if (drain_cnt_q <= DW'(1)) state_d = RUN;
      end
      RUN:     state_d = RUN;
      default: state_d = DRAIN;
    endcase
  end

  always_comb begin
    draining = (state_q == DRAIN);
  end

  assign issue_ready_o = (credits_q != '0) & ~draining;
  assign fp_start_o    = issue_valid_i & issue_ready_o;
  assign result_pop    = result_valid_o & result_ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits_q <= CW'(DEPTH);
    end else if (fp_start_o & ~result_pop) begin
      credits_q <= credits_q - CW'(1);
    end else if (result_pop & ~fp_start_o & (credits_q != CW'(DEPTH))) begin
      credits_q <= credits_q + CW'(1);
    end
  end

  assign credits_o = credits_q;

`ifdef VPU_FP_RBUF_BYPASS_EN
  assign bypass_valid = fp_done_i & ~draining & fifo_empty;
`else
  assign bypass_valid = 1'b0;
`endif

  // A bypassed result taken by the consumer this cycle is never written.
  assign fifo_push      = fp_done_i & ~draining & ~(bypass_valid & result_ready_i);
  assign result_valid_o = ~fifo_empty | bypass_valid;
  assign result_o       = bypass_valid ? fp_result_i : fifo_data;

  vpu_rbuf_fifo #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fp_result_i),
    .pop       (result_ready_i),
    .rd_data   (fifo_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .overflow  (overflow_o)
  );

endmodule

// File: tb/tb_vpu_fp_result_buffer.sv
// Self-checking bench for vpu_fp_result_buffer: directed steps plus random traffic
// checked against a queue-based reference model.
module tb_vpu_fp_result_buffer;

  localparam int DEPTH  = 8;
  localparam int DW     = 32;
  localparam int FP_LAT = 12;
  localparam int CW     = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          issue_valid_i = 1'b0;
  logic          issue_ready_o;
  logic          fp_start_o;
  logic          fp_done_i = 1'b0;
  logic [DW-1:0] fp_result_i = '0;
  logic          result_valid_o;
  logic [DW-1:0] result_o;
  logic          result_ready_i = 1'b0;
  logic [CW-1:0] credits_o;
  logic          overflow_o;

  always #5 clk = ~clk;

  vpu_fp_result_buffer #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DW),
    .FP_LATENCY (FP_LAT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .issue_valid_i  (issue_valid_i),
    .issue_ready_o  (issue_ready_o),
    .fp_start_o     (fp_start_o),
    .fp_done_i      (fp_done_i),
    .fp_result_i    (fp_result_i),
    .result_valid_o (result_valid_o),
    .result_o       (result_o),
    .result_ready_i (result_ready_i),
    .credits_o      (credits_o),
    .overflow_o     (overflow_o)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  logic [DW-1:0] q[$];
  int            credits;
  int            drain_left;
  bit            ovf;
  int            pend[$];
  int            cyc = 0;
  bit            e_ready, e_start, e_valid, e_byp;
  logic [DW-1:0] e_data;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    pend.delete();
    credits    = DEPTH;
    drain_left = FP_LAT;
    ovf        = 1'b0;
  endtask

  task automatic eval_check(string tag);
    string t;
    t       = $sformatf("%s@%0d", tag, cyc);
    e_ready = (credits != 0) && (drain_left == 0);
    e_start = issue_valid_i && e_ready;
    e_byp   = 1'b0;
`ifdef VPU_FP_RBUF_BYPASS_EN
    e_byp   = (drain_left == 0) && (q.size() == 0) && fp_done_i;
`endif
    e_valid = (q.size() > 0) || e_byp;
    e_data  = (q.size() > 0) ? q[0] : (e_byp ? fp_result_i : '0);
    check({t, ".ready"},   32'(issue_ready_o),  32'(e_ready));
    check({t, ".start"},   32'(fp_start_o),     32'(e_start));
    check({t, ".valid"},   32'(result_valid_o), 32'(e_valid));
    check({t, ".data"},    result_o,            e_data);
    check({t, ".credits"}, 32'(credits_o),      32'(credits));
    check({t, ".ovf"},     32'(overflow_o),     32'(ovf));
  endtask

  task automatic model_clock();
    bit pop;
    bit run;
    pop = e_valid && result_ready_i;
    run = (drain_left == 0);
    if (pop && q.size() > 0) void'(q.pop_front());
    if (fp_done_i && run && !(e_byp && result_ready_i)) begin
      if (q.size() < DEPTH) q.push_back(fp_result_i);
      else ovf = 1'b1;
    end
    if (e_start && !pop) credits--;
    else if (pop && !e_start && credits < DEPTH) credits++;
    if (drain_left > 0) drain_left--;
    if (e_start) pend.push_back(cyc + FP_LAT);
    cyc++;
  endtask

  task automatic step(bit iv, bit done, logic [DW-1:0] data, bit rr, string tag);
    @(negedge clk);
    issue_valid_i  = iv;
    fp_done_i      = done;
    fp_result_i    = data;
    result_ready_i = rr;
    #1;
    eval_check(tag);
    model_clock();
  endtask

  // Reset asserted between clock edges; outputs must clear without waiting for a clock.
  task automatic async_reset(string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    eval_check(tag);
    @(negedge clk);
    rst = 1'b0;
    #1;
    eval_check({tag, "_rel"});
    model_clock();
  endtask

  initial begin
    int  low_cnt;
    bit  done;
    logic [DW-1:0] rdata;

    // Drain window with issue held high; an early fp_done must be dropped.
    issue_valid_i = 1'b1;
    async_reset("rst0");
    low_cnt = issue_ready_o ? 0 : 1;
    for (int i = 0; i < 13; i++) begin
      step(1'b1, i == 4, 32'h3F80_0000, 1'b0, "drain");
      if (!issue_ready_o) low_cnt++;
    end
    check("drain_len", 32'(low_cnt), 32'd12);

    // Fill to zero credits, queue eight results, then drain in order.
    issue_valid_i = 1'b0;
    async_reset("rst1");
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, '0, 1'b0, "idle");
    for (int i = 0; i < 9; i++)  step(1'b1, 1'b0, '0, 1'b0, "issue");
    for (int i = 0; i < 8; i++)  step(1'b0, 1'b1, 32'h4000_0000 + DW'(i), 1'b0, "fill");
    for (int i = 0; i < 9; i++)  step(1'b0, 1'b0, '0, 1'b1, "pop");

    // Full FIFO with simultaneous pop and push: new datum lands last.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0, 1'b0, "issue2");
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 32'h5000_0000 + DW'(i), 1'b0, "fill2");
    step(1'b0, 1'b1, 32'hA5A5_A5A5, 1'b1, "full_pp");
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, '0, 1'b1, "drain_pp");

    // Push while full without pop: sticky overflow, contents untouched.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0, 1'b0, "issue3");
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 32'h6000_0000 + DW'(i), 1'b0, "fill3");
    step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, "ovf");
    step(1'b0, 1'b0, '0, 1'b0, "ovf_hold");
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, '0, 1'b1, "pop_ovf");
    async_reset("rst2");
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, '0, 1'b0, "idle2");

    // Empty FIFO, consumer ready: same-cycle with bypass, one cycle later without.
    step(1'b0, 1'b1, 32'h1111_1111, 1'b1, "byp");
    step(1'b0, 1'b0, '0, 1'b1, "byp_next");
    step(1'b0, 1'b1, 32'h2222_2222, 1'b1, "byp2");
    step(1'b0, 1'b0, '0, 1'b1, "byp2_next");

    // Random traffic with a modelled FP pipeline, async reset in mid-burst.
    pend.delete();
    for (int n = 0; n < 400; n++) begin
      if (n == 200) async_reset("rst_mid");
      done = (pend.size() > 0) && (pend[0] == cyc);
      if (done) void'(pend.pop_front());
      rdata = $urandom;
      step(1'($urandom_range(0, 1)), done, rdata, $urandom_range(0, 3) != 0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
